// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Register-file write-port arbiter between the pipeline WB stage and a
//   long-latency unit (mul/div). Long-latency results are buffered in a
//   2-entry in-order FIFO and written when the pipeline leaves the port idle.
//   If the FIFO head waits too long, the pipeline is stalled and the FIFO is
//   drained.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pipe_we/pipe_rd/pipe_data     pipeline WB write request
//   llu_valid/llu_rd/llu_data     long-latency result offer
//   llu_ready                     result accepted when valid && ready at an edge
//   rf_we/rf_rd/rf_wdata          register-file write port (combinational)
//   pipe_stall                    registered; holds IF..WB while high
//
// State | Meaning
// ------+-----------------------------------------------------------------
// NORMAL| pipeline has priority; FIFO head written on idle cycles
// DRAIN | pipeline stalled; FIFO head written every cycle until empty
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall
);

  localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT - 1);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [4:0]  rd_mem_q [2];
  logic [4:0]  rd_mem_d [2];
  logic [31:0] data_mem_q [2];
  logic [31:0] data_mem_d [2];
  logic [3:0]  age_q, age_d;

  logic fifo_empty;
  logic push;
  logic pop;
  logic pipe_elig;
  logic grant_pipe;
  logic grant_fifo;
  logic starve;

  assign pipe_stall = (state_q == DRAIN);

  always_comb begin
    fifo_empty = (count_q == 2'd0);
    // A pop in the same cycle does not free a slot, so ready depends only on
    // the registered count.
    llu_ready  = (count_q != 2'd2) && !rst;
    // x0 results are handshaken but never stored.
    push       = llu_valid && llu_ready && (llu_rd != 5'd0);
    pipe_elig  = pipe_we && (pipe_rd != 5'd0) && !pipe_stall && !rst;

    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (!rst) begin
      case (state_q)
        NORMAL: begin
          if (pipe_elig) grant_pipe = 1'b1;
          else           grant_fifo = !fifo_empty;
        end
        DRAIN:   grant_fifo = !fifo_empty;
        default: grant_fifo = 1'b0;
      endcase
    end
    pop = grant_fifo;

    rf_we    = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = 32'd0;
    if (grant_pipe) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_data;
    end else if (grant_fifo) begin
      rf_we    = 1'b1;
      rf_rd    = rd_mem_q[rd_ptr_q];
      rf_wdata = data_mem_q[rd_ptr_q];
    end

    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = llu_rd;
      data_mem_d[wr_ptr_q] = llu_data;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Age tracks how long the current head has been passed over.
    if (fifo_empty || pop)    age_d = 4'd0;
    else if (age_q != 4'hF)   age_d = age_q + 4'd1;
    else                      age_d = age_q;

    starve = !fifo_empty && !grant_fifo && (age_q == AGE_LIMIT);

    state_d = state_q;
    case (state_q)
      NORMAL:  if (starve) state_d = DRAIN;
      // A push on the final pop leaves a new head, so keep draining.
      DRAIN:   if (pop && (count_q == 2'd1) && !push) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_mem_q   <= '{default: '0};
      data_mem_q <= '{default: '0};
      age_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      age_q      <= age_d;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: cycles a buffered long-latency result may wait before the pipeline is stalled; legal range 2..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port pipe_we  input  1  pipeline WB stage requests a register write.
REQ-005 SHALL have port pipe_rd  input  5  pipeline destination register.
REQ-006 SHALL have port pipe_data  input  32  pipeline write data, from the WB select mux.
REQ-007 SHALL have port llu_valid  input  1  long-latency unit (mul/div) result valid.
REQ-008 SHALL have port llu_rd  input  5  long-latency destination register.
REQ-009 SHALL have port llu_data  input  32  long-latency result.
REQ-010 SHALL have port llu_ready  output  1  result accepted when llu_valid && llu_ready at a clock edge.
REQ-011 SHALL have port rf_we  output  1  register-file write enable.
REQ-012 SHALL have port rf_rd  output  5  register-file write address.
REQ-013 SHALL have port rf_wdata  output  32  register-file write data.
REQ-014 SHALL have port pipe_stall  output  1  registered; holds IF..WB stages while high.

Function
REQ-015 SHALL buffer accepted long-latency results in a 2-entry FIFO (rd, data), in order.
REQ-016 SHALL drive llu_ready = (FIFO count < 2) && !rst; a pop in the same cycle does not free a slot for that cycle's push.
REQ-017 SHALL accept and discard (no enqueue) any handshake with llu_rd == 0.
REQ-018 SHALL treat pipe write as eligible only when pipe_we && pipe_rd != 0 && !pipe_stall; pipe_we during pipe_stall is ignored (the stalled pipeline re-presents it).
REQ-019 SHALL implement FSM states NORMAL and DRAIN; pipe_stall = (state == DRAIN).
REQ-020 In NORMAL, SHALL grant the eligible pipe write; otherwise grant the FIFO head if the FIFO is non-empty; otherwise rf_we = 0.
REQ-021 In DRAIN, SHALL grant the FIFO head every cycle.
REQ-022 rf_we/rf_rd/rf_wdata SHALL be combinational from the grant in the same cycle; rf_rd and rf_wdata SHALL be 0 when rf_we = 0.
REQ-023 A granted FIFO head SHALL pop at that clock edge.
REQ-024 SHALL keep a 4-bit age counter: cleared on pop or when the FIFO is empty; incremented each cycle the head exists and is not granted.
REQ-025 NORMAL -> DRAIN at the edge where the head is not granted and age == STARVE_LIMIT-1.
REQ-026 DRAIN -> NORMAL at the edge where the pop empties the FIFO with no simultaneous push; a simultaneous push keeps the FSM in DRAIN.
REQ-027 Minimum latency from llu handshake to rf_we for that result SHALL be 1 cycle; the first clock edge after acceptance is the earliest grant edge.
REQ-028 SHALL never write two results in one cycle and never drop an accepted non-x0 result.
REQ-029 Ordering between same-rd pipe and llu results is the hazard unit's responsibility; this block preserves order only within the FIFO.

Reset
REQ-030 While rst is high: FIFO empty, age = 0, state = NORMAL, pipe_stall = 0, llu_ready = 0, rf_we = 0, rf_rd = 0, rf_wdata = 0, regardless of clk.
REQ-031 Reset asserted mid-DRAIN SHALL discard buffered results and deassert pipe_stall immediately; after release llu_ready = 1.

Verification
REQ-032 Idle pipe, llu handshake rd=5 data=0x1234 -> next cycle rf_we=1 rf_rd=5 rf_wdata=0x1234, FIFO empty after.
REQ-033 Continuous pipe_we rd=3 plus one llu result rd=7, STARVE_LIMIT=4 -> rd=3 writes for 4 cycles, pipe_stall=1 on cycle 5, rd=7 written that cycle, pipe_stall=0 on the following cycle.
REQ-034 Two llu results accepted while pipe busy -> llu_ready=0; third llu_valid held until a pop, then accepted the cycle after the pop.
REQ-035 llu handshake with rd=0 -> no enqueue, rf_we stays 0; pipe_we with rd=0 -> rf_we=0.
REQ-036 Push during the last DRAIN pop -> state stays DRAIN, new entry written next cycle, then NORMAL.
REQ-037 rst pulsed asynchronously with 2 entries buffered and pipe_stall=1 -> all outputs 0 before the next edge; no buffered write appears after release.
